// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Memory access unit: a MAR/MDR register pair in front of a synchronous
//   word memory, sequenced by a small FSM (IDLE, RD_WAIT, WR, DONE).
//   A read copies mem[MAR] into MDR after READ_LAT cycles. A write copies
//   MDR into mem[MAR] one cycle after the command. Both finish with a
//   one-cycle done pulse. err qualifies done when the command was
//   read+write together, or when MAR was out of range.
//
// Ports
//   clk         in   rising-edge clock
//   clr         in   asynchronous active-high reset (memory array untouched)
//   MAR_enable  in   load MAR from bus_Data[ADDR_W-1:0] (IDLE only)
//   MDR_enable  in   load MDR from bus_Data (IDLE only)
//   read        in   start read of mem[MAR] into MDR (IDLE only)
//   write       in   start write of MDR into mem[MAR] (IDLE only)
//   bus_Data    in   processor bus data, DATA_W bits
//   MAR_Data    out  current MAR value
//   MDR_Data    out  current MDR value
//   busy        out  high whenever the FSM is not in IDLE
//   done        out  one-cycle completion pulse
//   err         out  error flag, meaningful only while done=1

module mem_access_unit #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 9,
    parameter int DEPTH    = 512,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              MAR_enable,
    input  logic              MDR_enable,
    input  logic              read,
    input  logic              write,
    input  logic [DATA_W-1:0] bus_Data,
    output logic [ADDR_W-1:0] MAR_Data,
    output logic [DATA_W-1:0] MDR_Data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD_WAIT = 2'd1;
    localparam logic [1:0] S_WR      = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    // The index is only as wide as the array needs. Every access is also
    // gated by the range check, so the truncated index never aliases.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]      LAT_LAST = 4'(READ_LAT - 1);
    localparam logic [ADDR_W:0] DEPTH_V  = (ADDR_W + 1)'(DEPTH);

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] mdr;
    logic              err_q;
    logic              oor;
    logic [IDX_W-1:0]  idx;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    // MAR cannot change while busy, so checking the range during RD_WAIT/WR
    // gives the same result as checking it when the command was accepted.
    assign oor = ({1'b0, mar} >= DEPTH_V);
    assign idx = mar[IDX_W-1:0];

    assign MAR_Data = mar;
    assign MDR_Data = mdr;
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);
    assign err      = (state == S_DONE) && err_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            mar   <= '0;
            mdr   <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= 4'd0;
                    if (MAR_enable) mar <= bus_Data[ADDR_W-1:0];
                    if (MDR_enable) mdr <= bus_Data;
                    if (read && write) begin
                        // Conflicting command: skip the access, report the error.
                        state <= S_DONE;
                        err_q <= 1'b1;
                    end else if (read) begin
                        state <= S_RD_WAIT;
                    end else if (write) begin
                        state <= S_WR;
                    end
                end
                S_RD_WAIT: begin
                    if (cnt == LAT_LAST) begin
                        if (!oor) mdr <= mem[idx];
                        err_q <= oor;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_WR: begin
                    err_q <= oor;
                    state <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // The array has no reset. A clr during WR sends the state to IDLE right
    // away, so the write enable below never fires for an aborted command.
    always_ff @(posedge clk) begin
        if (state == S_WR && !oor) begin
            mem[idx] <= mdr;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk;
    logic        clr;
    logic        mar_en [2];
    logic        mdr_en [2];
    logic        rd     [2];
    logic        wr     [2];
    logic [31:0] bus    [2];
    logic [8:0]  mar_q  [2];
    logic [31:0] mdr_q  [2];
    logic        busy   [2];
    logic        done   [2];
    logic        err    [2];

    int checks = 0;
    int errors = 0;

    // Instance 0: READ_LAT=1, DEPTH=256 (MAR 0x100 is out of range).
    mem_access_unit #(.DATA_W(32), .ADDR_W(9), .DEPTH(256), .READ_LAT(1)) u_lat1 (
        .clk(clk), .clr(clr),
        .MAR_enable(mar_en[0]), .MDR_enable(mdr_en[0]),
        .read(rd[0]), .write(wr[0]), .bus_Data(bus[0]),
        .MAR_Data(mar_q[0]), .MDR_Data(mdr_q[0]),
        .busy(busy[0]), .done(done[0]), .err(err[0])
    );

    // Instance 1: READ_LAT=4, default depth.
    mem_access_unit #(.DATA_W(32), .ADDR_W(9), .DEPTH(512), .READ_LAT(4)) u_lat4 (
        .clk(clk), .clr(clr),
        .MAR_enable(mar_en[1]), .MDR_enable(mdr_en[1]),
        .read(rd[1]), .write(wr[1]), .bus_Data(bus[1]),
        .MAR_Data(mar_q[1]), .MDR_Data(mdr_q[1]),
        .busy(busy[1]), .done(done[1]), .err(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one command for one cycle. Returns 1 time unit after the edge
    // that sampled it, with all of this instance's inputs back at zero.
    task automatic cmd(input int i, input logic me, input logic de,
                       input logic r, input logic w, input logic [31:0] b);
        mar_en[i] = me; mdr_en[i] = de; rd[i] = r; wr[i] = w; bus[i] = b;
        step();
        mar_en[i] = 1'b0; mdr_en[i] = 1'b0; rd[i] = 1'b0; wr[i] = 1'b0; bus[i] = '0;
    endtask

    initial begin
        clr = 1'b1;
        for (int i = 0; i < 2; i++) begin
            mar_en[i] = 1'b0; mdr_en[i] = 1'b0; rd[i] = 1'b0; wr[i] = 1'b0; bus[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_mar",  64'(mar_q[i]), 64'h0);
            chk("rst_mdr",  64'(mdr_q[i]), 64'h0);
            chk("rst_busy", 64'(busy[i]),  64'h0);
            chk("rst_done", 64'(done[i]),  64'h0);
            chk("rst_err",  64'(err[i]),   64'h0);
        end
        clr = 1'b0;

        // Write/read round trip at READ_LAT=1.
        cmd(0, 1, 0, 0, 0, 32'h1F);
        cmd(0, 0, 1, 0, 0, 32'hDEADBEEF);
        chk("wr_mar_load", 64'(mar_q[0]), 64'h1F);
        chk("wr_mdr_load", 64'(mdr_q[0]), 64'hDEADBEEF);
        cmd(0, 0, 0, 0, 1, 32'h0);
        chk("wr_busy_n",  64'(busy[0]), 64'h1);
        chk("wr_done_n",  64'(done[0]), 64'h0);
        step();
        chk("wr_done_n1", 64'(done[0]), 64'h1);
        chk("wr_err_n1",  64'(err[0]),  64'h0);
        step();
        chk("wr_done_n2", 64'(done[0]), 64'h0);
        chk("wr_busy_n2", 64'(busy[0]), 64'h0);
        cmd(0, 0, 1, 0, 0, 32'h0);
        chk("mdr_clear", 64'(mdr_q[0]), 64'h0);
        cmd(0, 0, 0, 1, 0, 32'h0);
        chk("rd_busy_n",  64'(busy[0]),  64'h1);
        chk("rd_done_n",  64'(done[0]),  64'h0);
        chk("rd_mdr_n",   64'(mdr_q[0]), 64'h0);
        step();
        chk("rd_done_n1", 64'(done[0]),  64'h1);
        chk("rd_err_n1",  64'(err[0]),   64'h0);
        chk("rd_mdr_n1",  64'(mdr_q[0]), 64'hDEADBEEF);
        step();
        chk("rd_busy_n2", 64'(busy[0]),  64'h0);

        // read and write together: error, no access.
        cmd(0, 0, 1, 0, 0, 32'h55);
        cmd(0, 0, 0, 1, 1, 32'h0);
        chk("cf_done", 64'(done[0]),  64'h1);
        chk("cf_err",  64'(err[0]),   64'h1);
        chk("cf_mdr",  64'(mdr_q[0]), 64'h55);
        step();
        chk("cf_busy_after", 64'(busy[0]), 64'h0);
        cmd(0, 0, 0, 1, 0, 32'h0);
        step();
        chk("cf_mem_kept", 64'(mdr_q[0]), 64'hDEADBEEF);
        chk("cf_rd_err",   64'(err[0]),   64'h0);
        step();

        // Out of range with DEPTH=256.
        cmd(0, 1, 0, 0, 0, 32'h0);
        cmd(0, 0, 1, 0, 0, 32'hA5A5);
        cmd(0, 0, 0, 0, 1, 32'h0);
        step(); step();
        cmd(0, 1, 0, 0, 0, 32'h100);
        cmd(0, 0, 1, 0, 0, 32'h77);
        chk("oor_mar", 64'(mar_q[0]), 64'h100);
        cmd(0, 0, 0, 1, 0, 32'h0);
        step();
        chk("oor_rd_done", 64'(done[0]),  64'h1);
        chk("oor_rd_err",  64'(err[0]),   64'h1);
        chk("oor_rd_mdr",  64'(mdr_q[0]), 64'h77);
        step();
        cmd(0, 0, 0, 0, 1, 32'h0);
        step();
        chk("oor_wr_done", 64'(done[0]), 64'h1);
        chk("oor_wr_err",  64'(err[0]),  64'h1);
        step();
        cmd(0, 1, 0, 0, 0, 32'h0);
        cmd(0, 0, 0, 1, 0, 32'h0);
        step();
        chk("oor_mem0_kept", 64'(mdr_q[0]), 64'hA5A5);
        chk("oor_mem0_err",  64'(err[0]),   64'h0);
        step();

        // clr during WR aborts the write.
        cmd(0, 1, 0, 0, 0, 32'h5);
        cmd(0, 0, 1, 0, 0, 32'h1111);
        cmd(0, 0, 0, 0, 1, 32'h0);
        step(); step();
        cmd(0, 0, 1, 0, 0, 32'h1234);
        cmd(0, 0, 0, 0, 1, 32'h0);
        chk("ab_busy_wr", 64'(busy[0]), 64'h1);
        #1 clr = 1'b1;
        #2;
        chk("ab_mar",  64'(mar_q[0]), 64'h0);
        chk("ab_mdr",  64'(mdr_q[0]), 64'h0);
        chk("ab_busy", 64'(busy[0]),  64'h0);
        chk("ab_done", 64'(done[0]),  64'h0);
        #2 clr = 1'b0;
        step();
        chk("ab_done_1", 64'(done[0]), 64'h0);
        chk("ab_busy_1", 64'(busy[0]), 64'h0);
        step();
        chk("ab_done_2", 64'(done[0]), 64'h0);
        cmd(0, 1, 0, 0, 0, 32'h5);
        cmd(0, 0, 0, 1, 0, 32'h0);
        step();
        chk("ab_mem5_kept", 64'(mdr_q[0]), 64'h1111);
        chk("ab_mem5_err",  64'(err[0]),   64'h0);
        step();

        // READ_LAT=4, with commands asserted while busy.
        cmd(1, 1, 0, 0, 0, 32'h1F);
        cmd(1, 0, 1, 0, 0, 32'hCAFEF00D);
        cmd(1, 0, 0, 0, 1, 32'h0);
        step(); step();
        cmd(1, 0, 1, 0, 0, 32'h0);
        cmd(1, 0, 0, 1, 0, 32'h0);
        chk("l4_busy_n", 64'(busy[1]), 64'h1);
        chk("l4_done_n", 64'(done[1]), 64'h0);
        mar_en[1] = 1'b1; rd[1] = 1'b1; bus[1] = 32'h40;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk($sformatf("l4_busy_n%0d", k), 64'(busy[1]),  64'h1);
            chk($sformatf("l4_done_n%0d", k), 64'(done[1]),  64'h0);
            chk($sformatf("l4_mdr_n%0d", k),  64'(mdr_q[1]), 64'h0);
        end
        step();
        mar_en[1] = 1'b0; rd[1] = 1'b0; bus[1] = '0;
        chk("l4_done_n4", 64'(done[1]),  64'h1);
        chk("l4_err_n4",  64'(err[1]),   64'h0);
        chk("l4_mdr_n4",  64'(mdr_q[1]), 64'hCAFEF00D);
        chk("l4_mar_n4",  64'(mar_q[1]), 64'h1F);
        step();
        chk("l4_done_n5", 64'(done[1]), 64'h0);
        chk("l4_busy_n5", 64'(busy[1]), 64'h0);
        step();
        chk("l4_done_n6", 64'(done[1]),  64'h0);
        chk("l4_mar_end", 64'(mar_q[1]), 64'h1F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
